// File: rtl/chaos_pkg.sv
// Shared constants and types for the chaotic-keystream voice receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chaos_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 28;
    localparam int SAMPLE_W  = 16;

    // 1.0 in Q4.28; chaotic states must lie strictly below this
    localparam logic [DATA_W-1:0] ONE = 32'h1000_0000;

    // Keystream bits taken from the generator state for each sample
    localparam int KEY_HI = 27;
    localparam int KEY_LO = 12;
    localparam int KEY_W  = KEY_HI - KEY_LO + 1;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2
    } state_t;

    // Extract the keystream slice used to mask one voice sample
    function automatic logic [KEY_W-1:0] key_slice(input logic [DATA_W-1:0] key);
        return KEY_W'(key >> KEY_LO);
    endfunction

endpackage

// File: rtl/chaos_sync_receiver_if.sv
// Channel-in / plaintext-out handshake bundle for the chaos receiver.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the channel side and the sample side.
interface chaos_sync_receiver_if;

    logic        s_valid;
    logic        s_ready;
    logic        s_is_sync;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;

    // Receiver side: consumes channel words, produces samples
    modport slave (
        input  s_valid, s_is_sync, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    // Environment side: sources channel words, sinks samples
    modport master (
        output s_valid, s_is_sync, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

endinterface

// File: rtl/chaotic_generator.sv
// Logistic-map keystream generator (r = 4) in fixed point, loadable with a chaotic state.
// Latency: key_out is the current state; a load or advance shows on the next cycle.
// Backpressure: none; advances only when next_key_en is pulsed.
module chaotic_generator #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sync_en,
    input  logic [DATA_WIDTH-1:0] sync_state_in,
    input  logic                  next_key_en,
    output logic [DATA_WIDTH-1:0] key_out
);

    localparam logic [DATA_WIDTH-1:0] ONE_Q = DATA_WIDTH'(1) << FRAC_BITS;

    logic [DATA_WIDTH-1:0]   state_q;
    logic [DATA_WIDTH-1:0]   state_nxt;
    logic [2*DATA_WIDTH-1:0] prod;

    // x' = 4 * x * (1 - x): the x4 is folded into a shift two bits short of FRAC_BITS
    always_comb begin
        prod      = {{DATA_WIDTH{1'b0}}, state_q} * {{DATA_WIDTH{1'b0}}, ONE_Q - state_q};
        state_nxt = DATA_WIDTH'(prod >> (FRAC_BITS - 2));
    end

    // State register: a resync load wins over a keystream advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else if (sync_en) begin
            state_q <= sync_state_in;
        end else if (next_key_en) begin
            state_q <= state_nxt;
        end
    end

    assign key_out = state_q;

endmodule

// File: rtl/chaos_sync_receiver.sv
// Resynchronising chaotic-stream decryptor: sync words reload the generator, data words are XOR-unmasked.
// Latency: one cycle from accepted data word to m_valid.
// Backpressure: s_ready = !m_valid || m_ready while locked; stalled words never advance the keystream.
module chaos_sync_receiver
    import chaos_pkg::*;
#(
    parameter int MAX_RUN = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chaos_sync_receiver_if.slave  bus,
    output logic                  locked,
    output logic [15:0]           drop_cnt,
    output logic [7:0]            bad_sync_cnt
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);

    state_t              state_q;
    state_t              state_nxt;
    logic [RUN_W-1:0]    run_cnt;
    logic                s_ready_c;
    logic                sync_ok;
    logic                sync_en;
    logic                next_key_en;
    logic                out_load;
    logic                drop_inc;
    logic                bad_inc;
    logic                run_clr;
    logic                run_inc;
    logic [DATA_W-1:0]   key_out;
    logic                m_valid_q;
    logic [SAMPLE_W-1:0] m_data_q;

    assign sync_ok = (bus.s_data < ONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNSYNC;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state, channel ready and per-word action strobes
    always_comb begin
        state_nxt   = state_q;
        s_ready_c   = 1'b0;
        sync_en     = 1'b0;
        next_key_en = 1'b0;
        out_load    = 1'b0;
        drop_inc    = 1'b0;
        bad_inc     = 1'b0;
        run_clr     = 1'b0;
        run_inc     = 1'b0;

        case (state_q)
            UNSYNC: s_ready_c = 1'b1;
            LOAD: begin
                state_nxt = RUN;
                run_clr   = 1'b1;
            end
            RUN:     s_ready_c = !bus.m_valid || bus.m_ready;
            default: state_nxt = UNSYNC;
        endcase

        if (!rst_n) begin
            s_ready_c = 1'b0;
        end

        if (bus.s_valid && s_ready_c) begin
            if (bus.s_is_sync) begin
                if (sync_ok) begin
                    sync_en   = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    bad_inc = 1'b1;
                end
            end else if (state_q == RUN) begin
                if (run_cnt == RUN_W'(MAX_RUN)) begin
                    // Too long without a sync: assume the key has drifted
                    drop_inc  = 1'b1;
                    state_nxt = UNSYNC;
                end else begin
                    out_load    = 1'b1;
                    next_key_en = 1'b1;
                    run_inc     = 1'b1;
                end
            end else begin
                drop_inc = 1'b1;
            end
        end
    end

    // Output sample register: a reload keeps m_valid high across a same-cycle handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else if (out_load) begin
            m_valid_q <= 1'b1;
            m_data_q  <= bus.s_data[SAMPLE_W-1:0] ^ key_slice(key_out);
        end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    // Words since the last sync, bounding how far the keystream may free-run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (run_clr) begin
            run_cnt <= '0;
        end else if (run_inc) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end

    // Saturating diagnostics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt     <= '0;
            bad_sync_cnt <= '0;
        end else begin
            if (drop_inc && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (bad_inc && (bad_sync_cnt != 8'hFF)) begin
                bad_sync_cnt <= bad_sync_cnt + 8'd1;
            end
        end
    end

    chaotic_generator #(
        .DATA_WIDTH (DATA_W),
        .FRAC_BITS  (FRAC_BITS)
    ) u_gen (
        .clk           (clk),
        .rst           (!rst_n),
        .sync_en       (sync_en),
        .sync_state_in (bus.s_data),
        .next_key_en   (next_key_en),
        .key_out       (key_out)
    );

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign locked      = (state_q == RUN);

endmodule

// File: tb/tb_chaos_sync_receiver.sv
`timescale 1ns/1ps
module tb_chaos_sync_receiver;
    import chaos_pkg::*;

    localparam int MAX_RUN = 4;
    localparam int NV      = 15;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        locked;
    logic [15:0] drop_cnt;
    logic [7:0]  bad_sync_cnt;

    chaos_sync_receiver_if bus ();

    chaos_sync_receiver #(.MAX_RUN(MAX_RUN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .locked       (locked),
        .drop_cnt     (drop_cnt),
        .bad_sync_cnt (bad_sync_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard and reference model state
    logic [15:0] exp_q [$];
    logic [31:0] mdl_key    = '0;
    bit          mdl_locked = 1'b0;
    int          mdl_run    = 0;

    typedef struct {
        bit          is_sync;
        logic [31:0] data;
        bit          exp_locked;
        logic [15:0] exp_drop;
        logic [7:0]  exp_bad;
        bit          chk_m;
        logic [15:0] exp_m;
    } vec_t;

    vec_t vecs [NV];

    // Logistic map r=4 on Q4.28 values, computed in 64-bit arithmetic
    function automatic logic [31:0] lmap(input logic [31:0] x);
        longint unsigned xv;
        longint unsigned p;
        xv = 64'(x);
        p  = 64'd4 * xv * (64'(ONE) - xv);
        return 32'(p >> FRAC_BITS);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model and scoreboard, evaluated at negedge for handshakes that complete on the next posedge
    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_locked = 1'b0;
            mdl_run    = 0;
            exp_q.delete();
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got m_data 0x%0h, expected no sample", bus.m_data);
                end else begin
                    chk("out_sample", 32'(bus.m_data), 32'(exp_q.pop_front()));
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                if (bus.s_is_sync) begin
                    if (bus.s_data < ONE) begin
                        mdl_key    = bus.s_data;
                        mdl_locked = 1'b1;
                        mdl_run    = 0;
                    end
                end else if (mdl_locked) begin
                    if (mdl_run == MAX_RUN) begin
                        mdl_locked = 1'b0;
                    end else begin
                        exp_q.push_back(bus.s_data[15:0] ^ mdl_key[27:12]);
                        mdl_key = lmap(mdl_key);
                        mdl_run++;
                    end
                end
            end
        end
    end

    // Offer one word; called and returns at posedge+1
    task automatic send_word(input bit is_sync, input logic [31:0] data);
        int t;
        bus.s_valid   = 1'b1;
        bus.s_is_sync = is_sync;
        bus.s_data    = data;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.s_ready && t < 50);
        if (!bus.s_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: s_ready got 0 expected 1 for word 0x%0h", data);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] held;

        bus.s_valid   = 1'b0;
        bus.s_is_sync = 1'b0;
        bus.s_data    = '0;
        bus.m_ready   = 1'b1;

        //            sync  data           lock drop   bad   chk  m_data
        vecs[0]  = '{1'b0, 32'h0000_1234, 1'b0, 16'd1, 8'd0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 32'h0000_AAAA, 1'b0, 16'd2, 8'd0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 32'h0000_5555, 1'b0, 16'd3, 8'd0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 32'h1000_0000, 1'b0, 16'd3, 8'd1, 1'b0, 16'h0000};
        vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 1'b0, 16'd3, 8'd2, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 32'h01F9_7414, 1'b1, 16'd3, 8'd2, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 32'h0000_0000, 1'b1, 16'd3, 8'd2, 1'b1, 16'h1F97};
        vecs[7]  = '{1'b0, 32'h0000_1111, 1'b1, 16'd3, 8'd2, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 32'h0000_2222, 1'b1, 16'd3, 8'd2, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 32'h0000_3333, 1'b1, 16'd3, 8'd2, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 32'h0000_4444, 1'b0, 16'd4, 8'd2, 1'b0, 16'h0000};
        vecs[11] = '{1'b1, 32'h0ABC_DEF0, 1'b1, 16'd4, 8'd2, 1'b0, 16'h0000};
        vecs[12] = '{1'b0, 32'h0000_BEEF, 1'b1, 16'd4, 8'd2, 1'b1, 16'h1522};
        vecs[13] = '{1'b1, 32'h0C3A_5F17, 1'b1, 16'd4, 8'd2, 1'b0, 16'h0000};
        vecs[14] = '{1'b0, 32'h0000_0F0F, 1'b1, 16'd4, 8'd2, 1'b1, 16'hCCAA};

        // Reset values while rst_n is held low
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready",  32'(bus.s_ready),  32'd0);
        chk("rst_m_valid",  32'(bus.m_valid),  32'd0);
        chk("rst_m_data",   32'(bus.m_data),   32'd0);
        chk("rst_locked",   32'(locked),       32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt),     32'd0);
        chk("rst_bad_cnt",  32'(bad_sync_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("unsync_s_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;

        // Table: drops while unsynced, bad syncs, lock, MAX_RUN expiry, resync
        for (int i = 0; i < NV; i++) begin
            send_word(vecs[i].is_sync, vecs[i].data);
            idle(3);
            chk($sformatf("vec%0d_locked", i), 32'(locked),       32'(vecs[i].exp_locked));
            chk($sformatf("vec%0d_drop",   i), 32'(drop_cnt),     32'(vecs[i].exp_drop));
            chk($sformatf("vec%0d_bad",    i), 32'(bad_sync_cnt), 32'(vecs[i].exp_bad));
            if (vecs[i].chk_m) begin
                chk($sformatf("vec%0d_m_data", i), 32'(bus.m_data), 32'(vecs[i].exp_m));
            end
        end

        // Sink stall: one held sample, channel blocked, then a same-cycle reload
        bus.m_ready = 1'b0;
        send_word(1'b0, 32'h0000_1357);
        bus.s_valid   = 1'b1;
        bus.s_is_sync = 1'b0;
        bus.s_data    = 32'h0000_2468;
        held = exp_q[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_m_valid", 32'(bus.m_valid), 32'd1);
            chk("stall_m_data",  32'(bus.m_data),  32'(held));
            chk("stall_s_ready", 32'(bus.s_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.m_ready = 1'b1;
        @(negedge clk);
        chk("reload_s_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
        @(negedge clk);
        chk("reload_m_valid", 32'(bus.m_valid), 32'd1);
        @(posedge clk);
        #1;
        idle(2);

        // Reset mid-RUN with a sample pending
        bus.m_ready = 1'b0;
        send_word(1'b0, 32'h0000_7777);
        chk("pre_rst_m_valid", 32'(bus.m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("midrst_locked",  32'(locked),      32'd0);
        chk("midrst_s_ready", 32'(bus.s_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        bus.m_ready = 1'b1;
        send_word(1'b0, 32'h0000_1234);
        idle(3);
        chk("postrst_drop",   32'(drop_cnt), 32'd1);
        chk("postrst_locked", 32'(locked),   32'd0);
        send_word(1'b1, 32'h01F9_7414);
        send_word(1'b0, 32'h0000_0000);
        idle(3);
        chk("resync_m_data", 32'(bus.m_data), 32'h1F97);
        chk("resync_locked", 32'(locked),     32'd1);

        // Bad-sync counter saturation; state must stay locked
        for (int i = 0; i < 258; i++) begin
            send_word(1'b1, 32'hF000_0000 + 32'(i));
        end
        idle(2);
        chk("bad_sat",       32'(bad_sync_cnt), 32'hFF);
        chk("bad_sat_lock",  32'(locked),       32'd1);
        chk("bad_sat_drop",  32'(drop_cnt),     32'd1);

        idle(4);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chaos_sync_receiver.md
CHAOS_SYNC_RECEIVER -- requirements
Module: chaos_sync_receiver

Interface
REQ-001 SHALL have parameter MAX_RUN, default 1024: data words allowed between sync words before sync is declared lost.
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port s_valid, input, 1: channel word valid.
REQ-005 SHALL have port s_ready, output, 1: channel word accepted when s_valid && s_ready.
REQ-006 SHALL have port s_is_sync, input, 1: 1 = word carries a 32-bit chaotic state, 0 = word carries ciphertext in [15:0].
REQ-007 SHALL have port s_data, input, 32: channel word.
REQ-008 SHALL have port m_valid, output, 1: plaintext sample valid.
REQ-009 SHALL have port m_ready, input, 1: sink accepts when m_valid && m_ready.
REQ-010 SHALL have port m_data, output, 16: decrypted voice sample.
REQ-011 SHALL have port locked, output, 1: high in RUN state.
REQ-012 SHALL have port drop_cnt, output, 16: saturating count of data words discarded while unlocked.
REQ-013 SHALL have port bad_sync_cnt, output, 8: saturating count of rejected sync words.

Function
REQ-014 SHALL implement FSM states UNSYNC, LOAD, RUN; reset state UNSYNC.
REQ-015 Sync word SHALL be valid iff s_data < 0x10000000 (ONE, Q4.28); valid sync accepted in any state SHALL pulse generator sync_en with sync_state_in = s_data and go to LOAD.
REQ-016 Invalid sync word SHALL be accepted, increment bad_sync_cnt (saturate 0xFF), leave state unchanged.
REQ-017 LOAD SHALL last exactly one cycle with s_ready = 0, then go to RUN with run counter cleared.
REQ-018 In UNSYNC, s_ready SHALL be 1; data words SHALL be accepted and discarded, incrementing drop_cnt (saturate 0xFFFF).
REQ-019 In RUN, s_ready SHALL equal !m_valid || m_ready.
REQ-020 Accepted data word in RUN SHALL register m_data = s_data[15:0] XOR key_out[27:12] and set m_valid next cycle (latency 1); same cycle SHALL pulse next_key_en once.
REQ-021 m_valid/m_data SHALL hold stable until m_ready; m_valid SHALL clear on handshake with no new word.
REQ-022 Simultaneous output handshake and new accepted word SHALL reload m_data without m_valid dropping.
REQ-023 Run counter SHALL increment per accepted data word; a data word arriving with counter == MAX_RUN SHALL be discarded (drop_cnt++), locked SHALL fall, state -> UNSYNC.
REQ-024 Sync word in RUN SHALL not disturb a pending m_valid sample.
REQ-025 Keystream SHALL advance only on accepted data words in RUN, never on sync, dropped or stalled words.

Reset
REQ-026 On rst_n low: state UNSYNC, m_valid 0, m_data 0x0000, locked 0, drop_cnt 0, bad_sync_cnt 0, run counter 0, s_ready 0 while asserted.
REQ-027 Reset mid-RUN SHALL discard pending output; keystream SHALL be unusable until a new valid sync.
REQ-028 Generator reset input SHALL be driven by !rst_n; its reset state is never used for decryption.

Structure
REQ-029 Package chaos_pkg SHALL hold ONE (0x10000000), key slice bounds (27, 12), FSM state typedef.
REQ-030 SHALL instantiate exactly one sub-module, chaotic_generator (DATA_WIDTH 32, FRAC_BITS 28), driven via sync_en, sync_state_in, next_key_en.

Verification
REQ-031 Sync 0x01F97414, then data 0x0000 -> m_data 0x1F97, locked 1, one next_key_en pulse.
REQ-032 Sync 0x10000000 -> bad_sync_cnt 1, locked 0, no sync_en pulse.
REQ-033 Three data words in UNSYNC -> drop_cnt 3, m_valid never asserted.
REQ-034 RUN, m_ready held 0 for 5 cycles with s_valid 1 -> one sample held stable, s_ready 0, key advances once.
REQ-035 MAX_RUN = 4: sync then 5 data words -> 4 outputs, 5th dropped, locked 0, drop_cnt 1.
REQ-036 rst_n low mid-RUN with m_valid 1 -> m_valid 0 immediately; after release, data dropped until new sync.
